pattern_scan_ctrl: RTL and testbench

- Controller that sequences a serial shift-register pattern detector over a bounded frame of bits.
- Accepts a programmable pattern, length and overlap mode, then arms on `start`.
- Pulls bits through a valid/ready handshake, counts matches and records the first match position.
- Reports completion with a one-cycle `done` pulse.
- Sits between a serial bit source and status/config logic; generalises the fixed alternating-pattern detectors.

---
 rtl/pattern_scan_ctrl_if.sv | 15 +
 rtl/pattern_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if
//   Serial bit-source handshake between a bit producer and pattern_scan_ctrl.
//   din        : serial data bit (source -> controller)
//   din_valid  : din is valid this cycle (source -> controller)
//   din_ready  : controller accepts din this cycle (controller -> source)
//   master     : bit source side
//   slave      : controller side
interface pattern_scan_ctrl_if;
    logic din;
    logic din_valid;
    logic din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Sequences a serial shift-register pattern detector over a bounded frame.
//   A start with a valid config latches pattern/length/overlap/frame length and
//   begins a scan. Bits are pulled through the slave handshake, matches are
//   counted and the position of the first match is recorded. A one-cycle done
//   pulse marks frame completion.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : arm request (IDLE only), cancel (SCAN only)
//   cfg_pattern       : target pattern, right-aligned, newest bit is bit 0
//   cfg_len           : pattern length 1..PAT_W
//   cfg_overlap       : 1 = overlapping matches allowed
//   cfg_frame_len     : bits per frame 1..2^LEN_W-1
//   bits              : serial bit handshake (din, din_valid, din_ready)
//   busy              : high in SCAN and DONE
//   match             : one-cycle pulse per detected match
//   found, first_pos  : a match was seen / index of the first match
//   match_count       : saturating match counter
//   done, err         : frame-complete pulse / rejected-start pulse
// PAT_W must be at least 2.
module pattern_scan_ctrl #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int LEN_W = 8,
    localparam int LW = $clog2(PAT_W + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PAT_W-1:0]     cfg_pattern,
    input  logic [LW-1:0]        cfg_len,
    input  logic                 cfg_overlap,
    input  logic [LEN_W-1:0]     cfg_frame_len,
    pattern_scan_ctrl_if.slave   bits,
    output logic                 busy,
    output logic                 match,
    output logic                 found,
    output logic [LEN_W-1:0]     first_pos,
    output logic [CNT_W-1:0]     match_count,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [PAT_W-1:0] sr, sr_nx, pat_q, mask;
    logic [LW-1:0]    len_q, fill;
    logic             ovl_q;
    logic [LEN_W-1:0] flen_q, idx;
    logic             cfg_ok, arm, accept, hit, last_bit;

    always_comb begin
        cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(PAT_W)) && (cfg_frame_len != '0);
        arm      = (state == S_IDLE) && start && cfg_ok;
        accept   = (state == S_SCAN) && !abort && bits.din_valid;
        sr_nx    = {sr[PAT_W-2:0], bits.din};
        mask     = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (32'(len_q) > i);
        end
        // fill is the pre-update value, so the window holds fill+1 bits after this accept
        hit      = accept
                && (({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len_q})
                && ((sr_nx & mask) == (pat_q & mask));
        last_bit = accept && (idx == flen_q - 1'b1);
    end

    always_comb begin
        state_nx       = state;
        busy           = 1'b0;
        done           = 1'b0;
        bits.din_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_nx = S_SCAN;
            end
            S_SCAN: begin
                busy           = 1'b1;
                bits.din_ready = !abort;
                if (abort)         state_nx = S_IDLE;
                else if (last_bit) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sr          <= '0;
            fill        <= '0;
            idx         <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            flen_q      <= '0;
            match       <= 1'b0;
            found       <= 1'b0;
            first_pos   <= '0;
            match_count <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nx;
            match <= hit;
            err   <= (state == S_IDLE) && start && !cfg_ok;
            if (arm) begin
                pat_q       <= cfg_pattern;
                len_q       <= cfg_len;
                ovl_q       <= cfg_overlap;
                flen_q      <= cfg_frame_len;
                sr          <= '0;
                fill        <= '0;
                idx         <= '0;
                match_count <= '0;
                found       <= 1'b0;
                first_pos   <= '0;
            end else if (accept) begin
                sr  <= sr_nx;
                idx <= idx + 1'b1;
                if (hit && !ovl_q)      fill <= '0;
                else if (fill < len_q)  fill <= fill + 1'b1;
                if (hit) begin
                    if (match_count != '1) match_count <= match_count + 1'b1;
                    if (!found) begin
                        found     <= 1'b1;
                        first_pos <= idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl
//   Directed and randomized scans of pattern_scan_ctrl (PAT_W=3, CNT_W=2).
//   Expected match positions are computed per frame from the bit list itself:
//   a match at index i needs the newest len bits to equal the pattern and, in
//   non-overlap mode, len bits received since the previous match.
module tb_pattern_scan_ctrl;
    localparam int PAT_W = 3;
    localparam int CNT_W = 2;
    localparam int LEN_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, start, abort, cfg_overlap;
    logic [2:0]       cfg_pattern;
    logic [1:0]       cfg_len;
    logic [7:0]       cfg_frame_len;
    logic             busy, match, found, done, err;
    logic [7:0]       first_pos;
    logic [1:0]       match_count;

    pattern_scan_ctrl_if bus();

    pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_frame_len(cfg_frame_len), .bits(bus.slave),
        .busy(busy), .match(match), .found(found), .first_pos(first_pos),
        .match_count(match_count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sh_cnt, sh_found, sh_first;
    logic stim [256];
    logic exp_m [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, 32'(match_count), sh_cnt);
        check({tag, "_found"}, 32'(found), sh_found);
        check({tag, "_first"}, 32'(first_pos), sh_first);
    endtask

    // stop_kind: 0 = full frame, 1 = abort at index stop_at, 2 = reset at index stop_at
    task automatic scan(input logic [2:0] pat, input int len, input bit ovl, input int flen,
                        input int gap_lo, input int gap_hi, input int stop_at, input int stop_kind);
        int n, since, idx, gap, pend, cyc;
        bit eq;
        n = (stop_kind != 0) ? stop_at : flen;
        since = 0;
        for (int i = 0; i < n; i++) begin
            since++;
            eq = (i + 1 >= len);
            for (int k = 0; k < len && eq; k++)
                if (stim[i-k] != pat[k]) eq = 0;
            exp_m[i] = (since >= len) && eq;
            if (exp_m[i] && !ovl) since = 0;
        end

        @(negedge clk);
        start = 1'b1; cfg_pattern = pat; cfg_len = 2'(len); cfg_overlap = ovl;
        cfg_frame_len = 8'(flen); bus.din_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        sh_cnt = 0; sh_found = 0; sh_first = 0;
        check("busy_after_start", 32'(busy), 1);
        check("err_after_start", 32'(err), 0);
        check_results("cleared");

        idx = 0; gap = 0; pend = 0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (idx == n) break;
            start = 1'($urandom);
            cfg_pattern = 3'($urandom); cfg_len = 2'($urandom);
            cfg_overlap = 1'($urandom); cfg_frame_len = 8'($urandom);
            if (gap > 0) begin
                bus.din_valid = 1'b0; bus.din = 1'($urandom); gap--; pend = 0;
            end else begin
                bus.din_valid = 1'b1; bus.din = stim[idx];
                pend = exp_m[idx];
                if (pend != 0) begin
                    if (sh_cnt < CMAX) sh_cnt++;
                    if (sh_found == 0) begin sh_found = 1; sh_first = idx; end
                end
                idx++;
                gap = $urandom_range(gap_hi, gap_lo);
            end
            #1 check("din_ready_scan", 32'(bus.din_ready), 1);
            @(negedge clk);
            check("match", 32'(match), pend);
            check("err_scan", 32'(err), 0);
            check_results("run");
            if (idx != flen) check("done_early", 32'(done), 0);
        end
        if (cyc >= 2000) check("timeout", 0, 1);
        start = 1'b0;

        if (stop_kind == 0) begin
            check("done_pulse", 32'(done), 1);
            check("busy_done", 32'(busy), 1);
            bus.din_valid = 1'b1;
            #1 check("din_ready_done", 32'(bus.din_ready), 0);
            @(negedge clk);
            bus.din_valid = 1'b0;
            check("done_end", 32'(done), 0);
            check("busy_end", 32'(busy), 0);
            check("match_end", 32'(match), 0);
            check_results("final");
        end else if (stop_kind == 1) begin
            abort = 1'b1; bus.din_valid = 1'b1; bus.din = stim[idx];
            #1 check("din_ready_abort", 32'(bus.din_ready), 0);
            @(negedge clk);
            abort = 1'b0; bus.din_valid = 1'b0;
            check("busy_abort", 32'(busy), 0);
            check("done_abort", 32'(done), 0);
            check("match_abort", 32'(match), 0);
            check_results("abort");
            @(negedge clk);
            check("done_abort2", 32'(done), 0);
        end else begin
            reset = 1'b1; bus.din_valid = 1'b1; bus.din = 1'b1;
            @(negedge clk);
            reset = 1'b0; bus.din_valid = 1'b0;
            sh_cnt = 0; sh_found = 0; sh_first = 0;
            check("busy_rst", 32'(busy), 0);
            check("done_rst", 32'(done), 0);
            check("match_rst", 32'(match), 0);
            check("err_rst", 32'(err), 0);
            check("din_ready_rst", 32'(bus.din_ready), 0);
            check_results("rst");
            @(negedge clk);
            check("done_rst2", 32'(done), 0);
        end
    endtask

    task automatic err_start(input int len, input int flen);
        @(negedge clk);
        start = 1'b1; cfg_len = 2'(len); cfg_frame_len = 8'(flen);
        cfg_pattern = 3'($urandom); cfg_overlap = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        check("err_din_ready", 32'(bus.din_ready), 0);
        @(negedge clk);
        check("err_once", 32'(err), 0);
        check_results("err_hold");
    endtask

    task automatic load(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) stim[i] = v[n-1-i];
    endtask

    initial begin
        int len, flen, kind;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_frame_len = '0;
        bus.din = 1'b0; bus.din_valid = 1'b0;
        sh_cnt = 0; sh_found = 0; sh_first = 0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_match", 32'(match), 0);
        check("rst_err", 32'(err), 0);
        check("rst_din_ready", 32'(bus.din_ready), 0);
        check_results("rst_state");
        reset = 1'b0;

        // bits listed oldest first
        load(8'b101010, 6); scan(3'b101, 3, 1, 6, 0, 0, 0, 0);
        load(8'b101010, 6); scan(3'b101, 3, 0, 6, 0, 0, 0, 0);
        load(8'b10010,  5); scan(3'b010, 2, 1, 5, 2, 2, 0, 0);
        err_start(0, 5);
        err_start(2, 0);
        load(8'b101010, 6); scan(3'b101, 3, 1, 6, 0, 1, 3, 1);
        err_start(0, 0);
        load(8'b111111, 6); scan(3'b001, 1, 0, 6, 0, 0, 0, 0);
        load(8'b111111, 6); scan(3'b001, 1, 0, 6, 0, 0, 4, 2);

        for (int r = 0; r < 60; r++) begin
            len  = $urandom_range(3, 1);
            flen = $urandom_range(24, 1);
            for (int i = 0; i < flen; i++) stim[i] = 1'($urandom);
            kind = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
            scan(3'($urandom), len, 1'($urandom), flen, 0, 2,
                 int'($urandom_range(flen - 1, 0)), kind);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
